// File: rtl/pe_csc_loader.sv
// PE CSC loader: streams iact/weight CSC words from SRAM into one PE,
// then sequences the load, compute and clear handshakes for a work unit.
module pe_csc_loader #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             skip_weight,
  input  logic             clear_weight,
  input  logic [CNT_W-1:0] ia_len,
  input  logic [CNT_W-1:0] id_len,
  input  logic [CNT_W-1:0] wa_len,
  input  logic [CNT_W-1:0] wd_len,
  input  logic [9:0]       ia_base,
  input  logic [9:0]       id_base,
  input  logic [9:0]       wa_base,
  input  logic [9:0]       wd_base,
  output logic             ia_rd_en,
  output logic [9:0]       ia_rd_addr,
  output logic             id_rd_en,
  output logic [9:0]       id_rd_addr,
  output logic             wa_rd_en,
  output logic [9:0]       wa_rd_addr,
  output logic             wd_rd_en,
  output logic [9:0]       wd_rd_addr,
  input  logic [7:0]       ia_rdata,
  input  logic [12:0]      id_rdata,
  input  logic [6:0]       wa_rdata,
  input  logic [11:0]      wd_rdata,
  output logic             iact_address_in_valid,
  output logic [7:0]       iact_address_in,
  output logic             iact_data_in_valid,
  output logic [12:0]      iact_data_in,
  output logic             weight_address_in_valid,
  output logic [6:0]       weight_address_in,
  output logic             weight_data_in_valid,
  output logic [11:0]      weight_data_in,
  input  logic             all_write_fin,
  input  logic             cal_fin,
  output logic             do_load_en,
  output logic             iact_write_fin_clear,
  output logic             weight_write_fin_clear,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_IA,
    S_ID,
    S_WA,
    S_WD,
    S_WAIT_FIN,
    S_LOAD,
    S_CALC,
    S_CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [CNT_W-1:0] ia_len_q;
  logic [CNT_W-1:0] id_len_q;
  logic [CNT_W-1:0] wa_len_q;
  logic [CNT_W-1:0] wd_len_q;
  logic [9:0]       ia_base_q;
  logic [9:0]       id_base_q;
  logic [9:0]       wa_base_q;
  logic [9:0]       wd_base_q;
  logic             skip_q;
  logic             clrw_q;

  logic             ia_v_q;
  logic             id_v_q;
  logic             wa_v_q;
  logic             wd_v_q;
  logic             any_valid;

  assign any_valid = ia_v_q | id_v_q | wa_v_q | wd_v_q;
  assign busy      = (state != S_IDLE);

  // Data from SRAM arrives one cycle after the read; only forward it
  // while the matching beat is valid so idle outputs read as zero.
  assign iact_address_in_valid   = ia_v_q;
  assign iact_data_in_valid      = id_v_q;
  assign weight_address_in_valid = wa_v_q;
  assign weight_data_in_valid    = wd_v_q;
  assign iact_address_in   = ia_v_q ? ia_rdata : '0;
  assign iact_data_in      = id_v_q ? id_rdata : '0;
  assign weight_address_in = wa_v_q ? wa_rdata : '0;
  assign weight_data_in    = wd_v_q ? wd_rdata : '0;

  // State and stream word counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Work-unit config is captured only when a unit is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      ia_len_q  <= '0;
      id_len_q  <= '0;
      wa_len_q  <= '0;
      wd_len_q  <= '0;
      ia_base_q <= '0;
      id_base_q <= '0;
      wa_base_q <= '0;
      wd_base_q <= '0;
      skip_q    <= 1'b0;
      clrw_q    <= 1'b0;
    end else if (state == S_IDLE && start) begin
      ia_len_q  <= ia_len;
      id_len_q  <= id_len;
      wa_len_q  <= wa_len;
      wd_len_q  <= wd_len;
      ia_base_q <= ia_base;
      id_base_q <= id_base;
      wa_base_q <= wa_base;
      wd_base_q <= wd_base;
      skip_q    <= skip_weight;
      clrw_q    <= clear_weight;
    end
  end

  // PE-side valids track the SRAM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      ia_v_q <= 1'b0;
      id_v_q <= 1'b0;
      wa_v_q <= 1'b0;
      wd_v_q <= 1'b0;
    end else begin
      ia_v_q <= ia_rd_en;
      id_v_q <= id_rd_en;
      wa_v_q <= wa_rd_en;
      wd_v_q <= wd_rd_en;
    end
  end

  // Next state, counter and per-state outputs.
  always_comb begin
    state_nxt              = state;
    cnt_nxt                = cnt;
    ia_rd_en               = 1'b0;
    id_rd_en               = 1'b0;
    wa_rd_en               = 1'b0;
    wd_rd_en               = 1'b0;
    ia_rd_addr             = '0;
    id_rd_addr             = '0;
    wa_rd_addr             = '0;
    wd_rd_addr             = '0;
    do_load_en             = 1'b0;
    iact_write_fin_clear   = 1'b0;
    weight_write_fin_clear = 1'b0;
    done                   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_IA;
          cnt_nxt   = '0;
        end
      end
      S_IA: begin
        if (ia_len_q == '0) begin
          state_nxt = S_ID;
        end else begin
          ia_rd_en   = 1'b1;
          ia_rd_addr = ia_base_q + 10'(cnt);
          if (cnt == ia_len_q - ONE) begin
            cnt_nxt   = '0;
            state_nxt = S_ID;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      S_ID: begin
        if (id_len_q == '0) begin
          state_nxt = skip_q ? S_WAIT_FIN : S_WA;
        end else begin
          id_rd_en   = 1'b1;
          id_rd_addr = id_base_q + 10'(cnt);
          if (cnt == id_len_q - ONE) begin
            cnt_nxt   = '0;
            state_nxt = skip_q ? S_WAIT_FIN : S_WA;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      S_WA: begin
        if (wa_len_q == '0) begin
          state_nxt = S_WD;
        end else begin
          wa_rd_en   = 1'b1;
          wa_rd_addr = wa_base_q + 10'(cnt);
          if (cnt == wa_len_q - ONE) begin
            cnt_nxt   = '0;
            state_nxt = S_WD;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      S_WD: begin
        if (wd_len_q == '0) begin
          state_nxt = S_WAIT_FIN;
        end else begin
          wd_rd_en   = 1'b1;
          wd_rd_addr = wd_base_q + 10'(cnt);
          if (cnt == wd_len_q - ONE) begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_FIN;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      S_WAIT_FIN: begin
        if (all_write_fin && !any_valid) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        do_load_en = 1'b1;
        state_nxt  = S_CALC;
      end
      S_CALC: begin
        if (cal_fin) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        iact_write_fin_clear   = 1'b1;
        weight_write_fin_clear = clrw_q;
        done                   = 1'b1;
        state_nxt              = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_csc_loader.sv
// Directed bench for pe_csc_loader: cycle-exact stream, handshake,
// wrap, skip, clear and mid-unit reset scenarios against an SRAM model.
module tb_pe_csc_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        skip_weight;
  logic        clear_weight;
  logic [5:0]  ia_len, id_len, wa_len, wd_len;
  logic [9:0]  ia_base, id_base, wa_base, wd_base;
  logic        ia_rd_en, id_rd_en, wa_rd_en, wd_rd_en;
  logic [9:0]  ia_rd_addr, id_rd_addr, wa_rd_addr, wd_rd_addr;
  logic [7:0]  ia_rdata = '0;
  logic [12:0] id_rdata = '0;
  logic [6:0]  wa_rdata = '0;
  logic [11:0] wd_rdata = '0;
  logic        iact_address_in_valid, iact_data_in_valid;
  logic        weight_address_in_valid, weight_data_in_valid;
  logic [7:0]  iact_address_in;
  logic [12:0] iact_data_in;
  logic [6:0]  weight_address_in;
  logic [11:0] weight_data_in;
  logic        all_write_fin, cal_fin;
  logic        do_load_en, iact_write_fin_clear, weight_write_fin_clear;
  logic        busy, done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int ra[4][$];
  int rc[4][$];
  int bd[4][$];
  int bc[4][$];
  int n_load = 0;
  int n_done = 0;
  int n_iclr = 0;
  int n_wclr = 0;
  int overlap = 0;
  int load_cyc = 0;
  int done_cyc = 0;
  int wclr_cyc = 0;

  pe_csc_loader #(.CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start),
    .skip_weight(skip_weight), .clear_weight(clear_weight),
    .ia_len(ia_len), .id_len(id_len),
    .wa_len(wa_len), .wd_len(wd_len),
    .ia_base(ia_base), .id_base(id_base),
    .wa_base(wa_base), .wd_base(wd_base),
    .ia_rd_en(ia_rd_en), .ia_rd_addr(ia_rd_addr),
    .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
    .wa_rd_en(wa_rd_en), .wa_rd_addr(wa_rd_addr),
    .wd_rd_en(wd_rd_en), .wd_rd_addr(wd_rd_addr),
    .ia_rdata(ia_rdata), .id_rdata(id_rdata),
    .wa_rdata(wa_rdata), .wd_rdata(wd_rdata),
    .iact_address_in_valid(iact_address_in_valid),
    .iact_address_in(iact_address_in),
    .iact_data_in_valid(iact_data_in_valid),
    .iact_data_in(iact_data_in),
    .weight_address_in_valid(weight_address_in_valid),
    .weight_address_in(weight_address_in),
    .weight_data_in_valid(weight_data_in_valid),
    .weight_data_in(weight_data_in),
    .all_write_fin(all_write_fin), .cal_fin(cal_fin),
    .do_load_en(do_load_en),
    .iact_write_fin_clear(iact_write_fin_clear),
    .weight_write_fin_clear(weight_write_fin_clear),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic int pat(input int k, input int a);
    case (k)
      0: return (a & 255) ^ 'hA5;
      1: return 'h1400 | a;
      2: return (a & 127) ^ 'h33;
      default: return 'h800 | a;
    endcase
  endfunction

  // Cycle counter and one-cycle-latency SRAM model.
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    ia_rdata <= 8'(pat(0, int'(ia_rd_addr)));
    id_rdata <= 13'(pat(1, int'(id_rd_addr)));
    wa_rdata <= 7'(pat(2, int'(wa_rd_addr)));
    wd_rdata <= 12'(pat(3, int'(wd_rd_addr)));
  end

  // Mid-cycle recorder of reads, beats and pulses.
  always @(negedge clock) begin
    if (ia_rd_en) begin ra[0].push_back(int'(ia_rd_addr)); rc[0].push_back(cyc); end
    if (id_rd_en) begin ra[1].push_back(int'(id_rd_addr)); rc[1].push_back(cyc); end
    if (wa_rd_en) begin ra[2].push_back(int'(wa_rd_addr)); rc[2].push_back(cyc); end
    if (wd_rd_en) begin ra[3].push_back(int'(wd_rd_addr)); rc[3].push_back(cyc); end
    if (iact_address_in_valid) begin
      bd[0].push_back(int'(iact_address_in)); bc[0].push_back(cyc);
    end
    if (iact_data_in_valid) begin
      bd[1].push_back(int'(iact_data_in)); bc[1].push_back(cyc);
    end
    if (weight_address_in_valid) begin
      bd[2].push_back(int'(weight_address_in)); bc[2].push_back(cyc);
    end
    if (weight_data_in_valid) begin
      bd[3].push_back(int'(weight_data_in)); bc[3].push_back(cyc);
    end
    if (int'(ia_rd_en) + int'(id_rd_en) + int'(wa_rd_en) + int'(wd_rd_en) > 1)
      overlap <= overlap + 1;
    if (do_load_en) begin n_load <= n_load + 1; load_cyc <= cyc; end
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (iact_write_fin_clear) n_iclr <= n_iclr + 1;
    if (weight_write_fin_clear) begin n_wclr <= n_wclr + 1; wclr_cyc <= cyc; end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic clr_log();
    for (int k = 0; k < 4; k++) begin
      ra[k].delete(); rc[k].delete(); bd[k].delete(); bc[k].delete();
    end
  endtask

  task automatic do_start(input int ial, idl, wal, wdl,
                          input int iab, idb, wab, wdb,
                          input logic sk, cl, output int s);
    tick();
    ia_len = 6'(ial); id_len = 6'(idl); wa_len = 6'(wal); wd_len = 6'(wdl);
    ia_base = 10'(iab); id_base = 10'(idb);
    wa_base = 10'(wab); wd_base = 10'(wdb);
    skip_weight = sk; clear_weight = cl; start = 1'b1;
    s = cyc + 1;
    tick();
    start = 1'b0;
    ia_len = 6'd63; id_len = 6'd63; wa_len = 6'd63; wd_len = 6'd63;
    ia_base = 10'd999; id_base = 10'd999;
    wa_base = 10'd999; wd_base = 10'd999;
    skip_weight = ~sk; clear_weight = ~cl;
  endtask

  task automatic test_reset();
    logic [12:0] ctl;
    reset = 1'b1; start = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    ctl = {ia_rd_en, id_rd_en, wa_rd_en, wd_rd_en,
           iact_address_in_valid, iact_data_in_valid,
           weight_address_in_valid, weight_data_in_valid,
           do_load_en, iact_write_fin_clear, weight_write_fin_clear,
           busy, done};
    checks++;
    if (ctl !== '0) begin
      errors++; $display("FAIL reset_ctl got %b want 0", ctl);
    end
    checks++;
    if ({ia_rd_addr, id_rd_addr, wa_rd_addr, wd_rd_addr} !== '0) begin
      errors++; $display("FAIL reset_addr got %h want 0",
        {ia_rd_addr, id_rd_addr, wa_rd_addr, wd_rd_addr});
    end
    checks++;
    if ({iact_address_in, iact_data_in, weight_address_in, weight_data_in} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0",
        {iact_address_in, iact_data_in, weight_address_in, weight_data_in});
    end
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ia_rd_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b rd=%b want 0 0",
        busy, ia_rd_en);
    end
  endtask

  task automatic test_full(input string tag);
    int s, l0, d0, i0, w0, o0, a;
    int base[4], len[4], off[4];
    base = '{0, 16, 32, 48};
    len  = '{3, 4, 2, 5};
    off  = '{0, 3, 7, 9};
    clr_log();
    l0 = n_load; d0 = n_done; i0 = n_iclr; w0 = n_wclr; o0 = overlap;
    do_start(3, 4, 2, 5, 0, 16, 32, 48, 1'b0, 1'b1, s);
    goto(s + 17); all_write_fin = 1'b1;
    tick(); all_write_fin = 1'b0;
    goto(s + 21); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 24);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ra[k].size() != len[k] || bd[k].size() != len[k]) begin
        errors++;
        $display("FAIL %s count s%0d got rd=%0d beats=%0d want %0d",
          tag, k, ra[k].size(), bd[k].size(), len[k]);
      end else begin
        for (int i = 0; i < len[k]; i++) begin
          a = (base[k] + i) % 1024;
          checks++;
          if (ra[k][i] != a || rc[k][i] != s + off[k] + i) begin
            errors++;
            $display("FAIL %s rd s%0d[%0d] got %0d@%0d want %0d@%0d", tag, k, i,
              ra[k][i], rc[k][i], a, s + off[k] + i);
          end
          checks++;
          if (bd[k][i] != pat(k, a) || bc[k][i] != s + off[k] + i + 1) begin
            errors++;
            $display("FAIL %s beat s%0d[%0d] got %0h@%0d want %0h@%0d", tag, k, i,
              bd[k][i], bc[k][i], pat(k, a), s + off[k] + i + 1);
          end
        end
      end
    end
    checks++;
    if (overlap != o0) begin
      errors++; $display("FAIL %s overlap got %0d want 0", tag, overlap - o0);
    end
    checks++;
    if (n_load - l0 != 1 || load_cyc != s + 18) begin
      errors++; $display("FAIL %s load got %0d@%0d want 1@%0d", tag,
        n_load - l0, load_cyc, s + 18);
    end
    checks++;
    if (n_done - d0 != 1 || done_cyc != s + 22) begin
      errors++; $display("FAIL %s done got %0d@%0d want 1@%0d", tag,
        n_done - d0, done_cyc, s + 22);
    end
    checks++;
    if (n_iclr - i0 != 1 || n_wclr - w0 != 1) begin
      errors++; $display("FAIL %s clears got %0d/%0d want 1/1", tag,
        n_iclr - i0, n_wclr - w0);
    end
  endtask

  task automatic test_skip();
    int s, l0;
    clr_log();
    l0 = n_load;
    all_write_fin = 1'b1;
    do_start(2, 2, 3, 3, 100, 200, 300, 400, 1'b1, 1'b0, s);
    goto(s + 7); all_write_fin = 1'b0;
    goto(s + 8); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 11);
    checks++;
    if (ra[2].size() + ra[3].size() + bd[2].size() + bd[3].size() != 0) begin
      errors++; $display("FAIL skip_weight_traffic got %0d want 0",
        ra[2].size() + ra[3].size() + bd[2].size() + bd[3].size());
    end
    checks++;
    if (ra[0].size() != 2 || ra[1].size() != 2) begin
      errors++; $display("FAIL skip_iact_count got %0d/%0d want 2/2",
        ra[0].size(), ra[1].size());
    end else begin
      checks++;
      if (ra[0][1] != 101 || ra[1][0] != 200 || rc[1][1] != s + 3) begin
        errors++; $display("FAIL skip_iact_addr got %0d %0d @%0d want 101 200 @%0d",
          ra[0][1], ra[1][0], rc[1][1], s + 3);
      end
    end
    checks++;
    if (n_load - l0 != 1 || load_cyc != s + 6) begin
      errors++; $display("FAIL skip_load got %0d@%0d want 1@%0d",
        n_load - l0, load_cyc, s + 6);
    end
  endtask

  task automatic test_zero_len();
    int s, l0;
    clr_log();
    l0 = n_load;
    do_start(1, 0, 1, 1, 5, 6, 7, 8, 1'b0, 1'b0, s);
    goto(s + 5); all_write_fin = 1'b1;
    tick(); all_write_fin = 1'b0;
    goto(s + 8); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 11);
    checks++;
    if (ra[1].size() != 0 || bd[1].size() != 0) begin
      errors++; $display("FAIL zero_id got rd=%0d beats=%0d want 0 0",
        ra[1].size(), bd[1].size());
    end
    checks++;
    if (rc[2].size() != 1 || rc[3].size() != 1) begin
      errors++; $display("FAIL zero_w_count got %0d/%0d want 1/1",
        rc[2].size(), rc[3].size());
    end else begin
      checks++;
      if (rc[2][0] != s + 2 || rc[3][0] != s + 3 || ra[2][0] != 7) begin
        errors++; $display("FAIL zero_w_time got %0d %0d a%0d want %0d %0d a7",
          rc[2][0], rc[3][0], ra[2][0], s + 2, s + 3);
      end
    end
    checks++;
    if (n_load - l0 != 1 || load_cyc != s + 6) begin
      errors++; $display("FAIL zero_load got %0d@%0d want 1@%0d",
        n_load - l0, load_cyc, s + 6);
    end
  endtask

  task automatic test_wrap();
    int s;
    int exp_a[4];
    exp_a = '{1022, 1023, 0, 1};
    clr_log();
    do_start(4, 1, 2, 2, 1022, 0, 0, 0, 1'b1, 1'b0, s);
    goto(s + 6); all_write_fin = 1'b1;
    tick(); all_write_fin = 1'b0;
    goto(s + 9); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 12);
    checks++;
    if (ra[0].size() != 4 || bd[0].size() != 4) begin
      errors++; $display("FAIL wrap_count got %0d/%0d want 4/4",
        ra[0].size(), bd[0].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ra[0][i] != exp_a[i] || bd[0][i] != pat(0, exp_a[i])) begin
          errors++; $display("FAIL wrap[%0d] got a%0d d%0h want a%0d d%0h", i,
            ra[0][i], bd[0][i], exp_a[i], pat(0, exp_a[i]));
        end
      end
    end
  endtask

  task automatic test_clear(input logic cl, input int want_w);
    int s, d0, i0, w0;
    clr_log();
    d0 = n_done; i0 = n_iclr; w0 = n_wclr;
    do_start(1, 1, 1, 1, 0, 0, 0, 0, 1'b0, cl, s);
    goto(s + 1); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 5); all_write_fin = 1'b1;
    tick(); all_write_fin = 1'b0;
    goto(s + 8);
    start = 1'b1; clear_weight = ~cl; skip_weight = 1'b1;
    ia_len = 6'd3; ia_base = 10'd77;
    tick(); start = 1'b0;
    goto(s + 10); cal_fin = 1'b1;
    tick(); cal_fin = 1'b0;
    goto(s + 13);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clr%0d_idle got busy=%b want 0", cl, busy);
    end
    checks++;
    if (n_done - d0 != 1 || done_cyc != s + 11) begin
      errors++; $display("FAIL clr%0d_done got %0d@%0d want 1@%0d", cl,
        n_done - d0, done_cyc, s + 11);
    end
    checks++;
    if (n_iclr - i0 != 1 || n_wclr - w0 != want_w) begin
      errors++; $display("FAIL clr%0d_pulses got i%0d w%0d want i1 w%0d", cl,
        n_iclr - i0, n_wclr - w0, want_w);
    end
    checks++;
    if (ra[0].size() + ra[1].size() + ra[2].size() + ra[3].size() != 4) begin
      errors++; $display("FAIL clr%0d_reads got %0d want 4", cl,
        ra[0].size() + ra[1].size() + ra[2].size() + ra[3].size());
    end
  endtask

  task automatic test_reset_mid();
    int s, d0, i0, w0;
    logic [12:0] ctl;
    clr_log();
    d0 = n_done; i0 = n_iclr; w0 = n_wclr;
    do_start(2, 4, 1, 1, 0, 16, 32, 48, 1'b0, 1'b1, s);
    goto(s + 4);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (iact_data_in_valid !== 1'b1 || iact_data_in !== 13'(pat(1, 17))) begin
      errors++; $display("FAIL mid_second_beat got v%b d%0h want v1 d%0h",
        iact_data_in_valid, iact_data_in, pat(1, 17));
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    ctl = {ia_rd_en, id_rd_en, wa_rd_en, wd_rd_en,
           iact_address_in_valid, iact_data_in_valid,
           weight_address_in_valid, weight_data_in_valid,
           do_load_en, iact_write_fin_clear, weight_write_fin_clear,
           busy, done};
    checks++;
    if (ctl !== '0) begin
      errors++; $display("FAIL mid_ctl got %b want 0", ctl);
    end
    checks++;
    if ({iact_data_in, iact_address_in, id_rd_addr} !== '0) begin
      errors++; $display("FAIL mid_data got %h want 0",
        {iact_data_in, iact_address_in, id_rd_addr});
    end
    goto(s + 12);
    checks++;
    if (bd[1].size() != 2 || ra[2].size() != 0) begin
      errors++; $display("FAIL mid_beats got id=%0d wa_rd=%0d want 2 0",
        bd[1].size(), ra[2].size());
    end
    checks++;
    if (n_done != d0 || n_iclr != i0 || n_wclr != w0) begin
      errors++; $display("FAIL mid_pulses got d%0d i%0d w%0d want 0 0 0",
        n_done - d0, n_iclr - i0, n_wclr - w0);
    end
    test_full("after_reset");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    skip_weight = 1'b0; clear_weight = 1'b0;
    ia_len = '0; id_len = '0; wa_len = '0; wd_len = '0;
    ia_base = '0; id_base = '0; wa_base = '0; wd_base = '0;
    all_write_fin = 1'b0; cal_fin = 1'b0;
    test_reset();
    test_full("full");
    test_skip();
    test_zero_len();
    test_wrap();
    test_clear(1'b1, 1);
    test_clear(1'b0, 0);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
